// File: rtl/wave_phase_gen.sv
// wave_phase_gen: numerically controlled phase generator for the sine lookup stage.
// A tuning-word accumulator sets frequency; new words are applied glitch-free at a
// period boundary (carry), immediately while stalled (en=0) or while the active word is 0.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   en             : advance the accumulator when high
//   tw_in, tw_load : new tuning word and its one-cycle capture strobe
//   tw_busy        : a loaded word is pending and not yet active
//   tw_ack         : one-cycle pulse after the pending word becomes active
//   count          : 9-bit phase index (accumulator top bits, plus optional offset)
//   wrap           : one-cycle pulse on accumulator carry-out
//   cycles         : completed periods since reset, modulo 2^CYC_W
//   phase_off      : 9-bit phase offset added to count (only with WAVE_PHASE_OFFSET_EN)
//
// Optional feature macro: WAVE_PHASE_OFFSET_EN (adds phase_off port).

module wave_phase_gen #(
  parameter int ACC_W = 24,
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [ACC_W-1:0] tw_in,
  input  logic             tw_load,
`ifdef WAVE_PHASE_OFFSET_EN
  input  logic [8:0]       phase_off,
`endif
  output logic             tw_busy,
  output logic             tw_ack,
  output logic [8:0]       count,
  output logic             wrap,
  output logic [CYC_W-1:0] cycles
);

  typedef enum logic {
    TW_IDLE    = 1'b0,
    TW_PENDING = 1'b1
  } tw_state_t;

  tw_state_t        state, state_nxt;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] tw_active;
  logic [ACC_W-1:0] tw_pending;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W-1:0] tw_sel;
  logic             apply;
  logic [8:0]       count_nxt;

  // Datapath and handshake decisions for this cycle.
  always_comb begin
    sum       = {1'b0, acc} + {1'b0, tw_active};
    // A stalled accumulator never produces a carry.
    carry     = en & sum[ACC_W];
    acc_nxt   = en ? sum[ACC_W-1:0] : acc;
    // A load in the same cycle as the apply takes precedence over the stored word.
    tw_sel    = tw_load ? tw_in : tw_pending;
    // Switching is only glitch-free at a period boundary, while stalled,
    // or while the generator is not running (active word of zero).
    apply     = ((state == TW_PENDING) || tw_load) &&
                (carry || !en || (tw_active == '0));
`ifdef WAVE_PHASE_OFFSET_EN
    count_nxt = acc_nxt[ACC_W-1 -: 9] + phase_off;
`else
    count_nxt = acc_nxt[ACC_W-1 -: 9];
`endif
  end

  // Pending-word state: IDLE <-> PENDING.
  always_comb begin
    state_nxt = state;
    if (apply) begin
      state_nxt = TW_IDLE;
    end else if (tw_load) begin
      state_nxt = TW_PENDING;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TW_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      tw_active  <= '0;
      tw_pending <= '0;
      tw_ack     <= 1'b0;
      count      <= '0;
      wrap       <= 1'b0;
      cycles     <= '0;
    end else begin
      acc    <= acc_nxt;
      count  <= count_nxt;
      wrap   <= carry;
      tw_ack <= apply;
      cycles <= cycles + {{(CYC_W-1){1'b0}}, carry};
      if (tw_load) begin
        tw_pending <= tw_in;
      end
      if (apply) begin
        tw_active <= tw_sel;
      end
    end
  end

  assign tw_busy = (state == TW_PENDING);

endmodule

// File: tb/tb_wave_phase_gen.sv
module tb_wave_phase_gen;

  localparam int ACC_W = 24;
  localparam int CYC_W = 16;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [ACC_W-1:0] tw_in;
  logic             tw_load;
  logic [8:0]       phase_off;
  logic             tw_busy;
  logic             tw_ack;
  logic [8:0]       count;
  logic             wrap;
  logic [CYC_W-1:0] cycles;

  int tests;
  int fails;

  wave_phase_gen #(.ACC_W(ACC_W), .CYC_W(CYC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .tw_in     (tw_in),
    .tw_load   (tw_load),
`ifdef WAVE_PHASE_OFFSET_EN
    .phase_off (phase_off),
`endif
    .tw_busy   (tw_busy),
    .tw_ack    (tw_ack),
    .count     (count),
    .wrap      (wrap),
    .cycles    (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        ld;
    logic [23:0] tw;
    int          cnt;
    logic        w;
    logic        b;
    logic        a;
    int          cyc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic e, logic l, logic [23:0] t, int c,
                              logic w, logic b, logic a, int cy);
    vec_t v;
    v.en = e; v.ld = l; v.tw = t; v.cnt = c;
    v.w = w; v.b = b; v.a = a; v.cyc = cy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Sample one time unit after the active edge; inputs change at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    en      = 1'b0;
    tw_load = 1'b0;
    tw_in   = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    tests     = 0;
    fails     = 0;
    phase_off = '0;

    // Reset state
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_busy", tw_busy, 0);
    chk("rst_ack", tw_ack, 0);
    chk("rst_cycles", cycles, 0);
    step();
    rst_n = 1'b1;

    // Table: tw 0x400000 wraps every 4 steps (count += 128).
    //            en ld tw         cnt  w  b  a  cyc
    vq.push_back(mk(1, 1, 24'h400000,   0, 0, 0, 1, 0)); // load while idle, active=0 -> immediate
    vq.push_back(mk(1, 0, 24'h000000, 128, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 24'h200000, 256, 0, 1, 0, 0)); // pending
    vq.push_back(mk(1, 1, 24'h100000, 384, 0, 1, 0, 0)); // overwrite pending
    vq.push_back(mk(1, 0, 24'h000000,   0, 1, 0, 1, 1)); // carry applies 0x100000
    vq.push_back(mk(1, 0, 24'h000000,  32, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 24'h000000,  32, 0, 0, 0, 1)); // hold
    vq.push_back(mk(0, 1, 24'hF00000,  32, 0, 0, 1, 1)); // load while stalled
    vq.push_back(mk(1, 0, 24'h000000,   0, 1, 0, 0, 2)); // 0x100000+0xF00000 carries
    vq.push_back(mk(1, 1, 24'h400000, 480, 0, 1, 0, 2));
    vq.push_back(mk(1, 0, 24'h000000, 448, 1, 0, 1, 3));
    vq.push_back(mk(1, 0, 24'h000000,  64, 1, 0, 0, 4));
    vq.push_back(mk(1, 0, 24'h000000, 192, 0, 0, 0, 4));
    vq.push_back(mk(1, 0, 24'h000000, 320, 0, 0, 0, 4));
    vq.push_back(mk(1, 0, 24'h000000, 448, 0, 0, 0, 4));
    vq.push_back(mk(1, 1, 24'h080000,  64, 1, 0, 1, 5)); // load coincident with carry
    vq.push_back(mk(1, 0, 24'h000000,  80, 0, 0, 0, 5));
    vq.push_back(mk(1, 1, 24'h000000,  96, 0, 1, 0, 5)); // pending zero word
    vq.push_back(mk(0, 0, 24'h000000,  96, 0, 0, 1, 5)); // stall applies it
    vq.push_back(mk(1, 0, 24'h000000,  96, 0, 0, 0, 5)); // zero word: frozen
    vq.push_back(mk(1, 0, 24'h000000,  96, 0, 0, 0, 5));
    vq.push_back(mk(1, 1, 24'h400000,  96, 0, 0, 1, 5)); // applies since active is 0
    vq.push_back(mk(1, 0, 24'h000000, 224, 0, 0, 0, 5));

    for (int i = 0; i < vq.size(); i++) begin
      en      = vq[i].en;
      tw_load = vq[i].ld;
      tw_in   = vq[i].tw;
      step();
      tw_load = 1'b0;
      chk($sformatf("tbl%0d_count", i), count, vq[i].cnt);
      chk($sformatf("tbl%0d_wrap", i), wrap, vq[i].w);
      chk($sformatf("tbl%0d_busy", i), tw_busy, vq[i].b);
      chk($sformatf("tbl%0d_ack", i), tw_ack, vq[i].a);
      chk($sformatf("tbl%0d_cycles", i), cycles, vq[i].cyc);
    end

    // Sequence: step of 1 per clk, three full periods
    do_reset();
    en      = 1'b1;
    tw_in   = 24'h008000;
    tw_load = 1'b1;
    step();
    tw_load = 1'b0;
    chk("seqA_ack", tw_ack, 1);
    chk("seqA_busy", tw_busy, 0);
    chk("seqA_count0", count, 0);
    bad = 0;
    for (int i = 0; i < 1536; i++) begin
      step();
      if (count !== 9'((i + 1) % 512)) bad++;
      if (wrap !== (((i + 1) % 512) == 0)) bad++;
      if (tw_ack !== 1'b0) bad++;
    end
    chk("seqA_bad_steps", bad, 0);
    chk("seqA_cycles", cycles, 3);

    // Sequence: load 0x010000 at count 100, applies at the next carry
    for (int i = 0; i < 100; i++) step();
    chk("seqB_count100", count, 100);
    tw_in   = 24'h010000;
    tw_load = 1'b1;
    step();
    tw_load = 1'b0;
    chk("seqB_busy", tw_busy, 1);
    chk("seqB_count101", count, 101);
    bad = 0;
    n   = 0;
    while (n < 600) begin
      step();
      n++;
      if (wrap) break;
      if (tw_busy !== 1'b1 || tw_ack !== 1'b0) bad++;
    end
    chk("seqB_busy_hold", bad, 0);
    chk("seqB_steps_to_wrap", n, 411);
    chk("seqB_ack_at_wrap", tw_ack, 1);
    chk("seqB_busy_clear", tw_busy, 0);
    chk("seqB_count_wrap", count, 0);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (count !== 9'((2 * (i + 1)) % 512)) bad++;
      if (wrap !== (i == 255)) bad++;
    end
    chk("seqB_step2_bad", bad, 0);
    chk("seqB_cycles", cycles, 5);

    // Sequence: stall for 50 clks, load while stalled
    for (int i = 0; i < 10; i++) step();
    chk("seqC_count20", count, 20);
    en  = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (count !== 9'd20 || cycles !== 16'd5 || wrap !== 1'b0) bad++;
    end
    chk("seqC_hold_bad", bad, 0);
    tw_in   = 24'h008000;
    tw_load = 1'b1;
    step();
    tw_load = 1'b0;
    chk("seqC_ack", tw_ack, 1);
    chk("seqC_busy", tw_busy, 0);
    en = 1'b1;
    step();
    chk("seqC_count21", count, 21);

    // Sequence: asynchronous reset between edges while a word is pending
    tw_in   = 24'h010000;
    tw_load = 1'b1;
    step();
    tw_load = 1'b0;
    chk("seqD_busy_pre", tw_busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("seqD_rst_count", count, 0);
    chk("seqD_rst_busy", tw_busy, 0);
    chk("seqD_rst_cycles", cycles, 0);
    chk("seqD_rst_wrap", wrap, 0);
    en = 1'b0;
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (tw_ack !== 1'b0 || tw_busy !== 1'b0 || count !== 9'd0) bad++;
    end
    chk("seqD_post_release", bad, 0);

`ifdef WAVE_PHASE_OFFSET_EN
    // Offset: count = acc top bits + 128, wrap follows acc carry only
    do_reset();
    phase_off = 9'd128;
    en        = 1'b1;
    tw_in     = 24'h008000;
    tw_load   = 1'b1;
    step();
    tw_load = 1'b0;
    chk("off_count0", count, 128);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      step();
      if (count !== 9'((i + 1 + 128) % 512)) bad++;
      if (wrap !== (i == 511)) bad++;
    end
    chk("off_seq_bad", bad, 0);
    chk("off_cycles", cycles, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
